// File: rtl/class_lu_req.sv
// Classifier main-path lookup initiator (port A): serializes keys into three bus beats
// and returns in-order tagged results. Optional counters under CLASS_LU_REQ_STATS_EN.
module class_lu_req #(
    parameter int KEY_LEN   = 276,
    parameter int BUS_WIDTH = 128,
    parameter int VID_WIDTH = 15,
    parameter int TAG_WIDTH = 8,
    parameter int MAX_OUTST = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       req_vld,
    output logic                       req_rdy,
    input  logic [KEY_LEN-1:0]         req_key,
    input  logic [TAG_WIDTH-1:0]       req_tag,
    output logic                       lu_vld,
    output logic [BUS_WIDTH-1:0]       lu_key,
    input  logic                       lu_done,
    input  logic                       lu_err,
    input  logic                       lu_hit_miss,
    input  logic [VID_WIDTH-1:0]       lu_vid,
    output logic                       rsp_vld,
    output logic [TAG_WIDTH-1:0]       rsp_tag,
    output logic                       rsp_err,
    output logic                       rsp_hit,
    output logic [VID_WIDTH-1:0]       rsp_vid,
    output logic [$clog2(MAX_OUTST):0] outst_cnt,
    output logic                       err_unexp_done
`ifdef CLASS_LU_REQ_STATS_EN
    ,
    input  logic                       stat_clr,
    output logic [31:0]                stat_req,
    output logic [31:0]                stat_hit,
    output logic [31:0]                stat_miss,
    output logic [31:0]                stat_err
`endif
);

    localparam int PW  = $clog2(MAX_OUTST);
    localparam int CW  = PW + 1;
    localparam int LOW = KEY_LEN - BUS_WIDTH;
    localparam int REM = KEY_LEN - 2 * BUS_WIDTH;
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTST);

    typedef enum logic [1:0] {IDLE, BEAT1, BEAT2, GAP} state_t;

    state_t                 state_r, state_s;
    logic                   lu_vld_r, lu_vld_s;
    logic [BUS_WIDTH-1:0]   lu_key_r, lu_key_s;
    logic [LOW-1:0]         key_r;
    logic [TAG_WIDTH-1:0]   tag_mem [MAX_OUTST];
    logic [PW-1:0]          wr_ptr_r, rd_ptr_r;
    logic [CW-1:0]          cnt_r;
    logic                   rsp_vld_r, rsp_err_r, rsp_hit_r, err_r;
    logic [TAG_WIDTH-1:0]   rsp_tag_r;
    logic [VID_WIDTH-1:0]   rsp_vid_r;
    logic                   accept_s, pop_s, unexp_s;

    // The first beat leaves straight from req_key, so only the lower beats are held.
    assign req_rdy  = (state_r == IDLE) && (cnt_r < MAX_CNT);
    assign accept_s = req_vld && req_rdy;
    assign pop_s    = lu_done && (cnt_r != '0);
    assign unexp_s  = lu_done && (cnt_r == '0);

    assign lu_vld         = lu_vld_r;
    assign lu_key         = lu_key_r;
    assign rsp_vld        = rsp_vld_r;
    assign rsp_tag        = rsp_tag_r;
    assign rsp_err        = rsp_err_r;
    assign rsp_hit        = rsp_hit_r;
    assign rsp_vid        = rsp_vid_r;
    assign outst_cnt      = cnt_r;
    assign err_unexp_done = err_r;

    // Beat sequencer: next state and next registered bus values.
    always_comb begin
        state_s  = state_r;
        lu_vld_s = 1'b0;
        lu_key_s = '0;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_s  = BEAT1;
                    lu_vld_s = 1'b1;
                    lu_key_s = req_key[KEY_LEN-1 -: BUS_WIDTH];
                end else begin
                    state_s = IDLE;
                end
            end
            BEAT1: begin
                state_s  = BEAT2;
                lu_key_s = key_r[LOW-1 -: BUS_WIDTH];
            end
            BEAT2: begin
                state_s  = GAP;
                lu_key_s = BUS_WIDTH'(key_r[REM-1:0]) << (BUS_WIDTH - REM);
            end
            GAP:     state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // Sequencer state, bus outputs and latched key.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= IDLE;
            lu_vld_r <= 1'b0;
            lu_key_r <= '0;
            key_r    <= '0;
        end else begin
            state_r  <= state_s;
            lu_vld_r <= lu_vld_s;
            lu_key_r <= lu_key_s;
            if (accept_s) key_r <= req_key[LOW-1:0];
        end
    end

    // Tag storage; validity is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (accept_s) tag_mem[wr_ptr_r] <= req_tag;
    end

    // In-flight bookkeeping: pointers, outstanding count, sticky protocol error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            cnt_r    <= '0;
            err_r    <= 1'b0;
        end else begin
            if (accept_s) wr_ptr_r <= wr_ptr_r + PW'(1);
            if (pop_s)    rd_ptr_r <= rd_ptr_r + PW'(1);
            if (unexp_s)  err_r    <= 1'b1;
            case ({accept_s, pop_s})
                2'b10:   cnt_r <= cnt_r + CW'(1);
                2'b01:   cnt_r <= cnt_r - CW'(1);
                default: cnt_r <= cnt_r;
            endcase
        end
    end

    // Response register: one-cycle strobe, data held until the next result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_vld_r <= 1'b0;
            rsp_tag_r <= '0;
            rsp_err_r <= 1'b0;
            rsp_hit_r <= 1'b0;
            rsp_vid_r <= '0;
        end else begin
            rsp_vld_r <= pop_s;
            if (pop_s) begin
                rsp_tag_r <= tag_mem[rd_ptr_r];
                rsp_err_r <= lu_err;
                rsp_hit_r <= lu_hit_miss & ~lu_err;
                rsp_vid_r <= lu_vid;
            end
        end
    end

`ifdef CLASS_LU_REQ_STATS_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
        return (en && (v != 32'hFFFF_FFFF)) ? v + 32'd1 : v;
    endfunction

    // Saturating event counters; clear wins over counting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_req  <= 32'd0;
            stat_hit  <= 32'd0;
            stat_miss <= 32'd0;
            stat_err  <= 32'd0;
        end else if (stat_clr) begin
            stat_req  <= 32'd0;
            stat_hit  <= 32'd0;
            stat_miss <= 32'd0;
            stat_err  <= 32'd0;
        end else begin
            stat_req  <= sat_inc(stat_req, accept_s);
            stat_hit  <= sat_inc(stat_hit, pop_s & lu_hit_miss & ~lu_err);
            stat_miss <= sat_inc(stat_miss, pop_s & ~lu_hit_miss & ~lu_err);
            stat_err  <= sat_inc(stat_err, (pop_s & lu_err) | unexp_s);
        end
    end
`endif

endmodule

// File: tb/tb_class_lu_req.sv
// Bench for class_lu_req: directed stimulus, an abstract per-cycle model and literal pins.
module tb_class_lu_req;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         req_vld = 1'b0;
    logic         req_rdy;
    logic [275:0] req_key = '0;
    logic [7:0]   req_tag = '0;
    logic         lu_vld;
    logic [127:0] lu_key;
    logic         lu_done = 1'b0, lu_err = 1'b0, lu_hit_miss = 1'b0;
    logic [14:0]  lu_vid = '0;
    logic         rsp_vld, rsp_err, rsp_hit, err_unexp_done;
    logic [7:0]   rsp_tag;
    logic [14:0]  rsp_vid;
    logic [4:0]   outst_cnt;
`ifdef CLASS_LU_REQ_STATS_EN
    logic         stat_clr = 1'b0;
    logic [31:0]  stat_req, stat_hit, stat_miss, stat_err;
`endif

    class_lu_req dut (
        .clk(clk), .rst_n(rst_n), .req_vld(req_vld), .req_rdy(req_rdy),
        .req_key(req_key), .req_tag(req_tag), .lu_vld(lu_vld), .lu_key(lu_key),
        .lu_done(lu_done), .lu_err(lu_err), .lu_hit_miss(lu_hit_miss), .lu_vid(lu_vid),
        .rsp_vld(rsp_vld), .rsp_tag(rsp_tag), .rsp_err(rsp_err), .rsp_hit(rsp_hit),
        .rsp_vid(rsp_vid), .outst_cnt(outst_cnt), .err_unexp_done(err_unexp_done)
`ifdef CLASS_LU_REQ_STATS_EN
        , .stat_clr(stat_clr), .stat_req(stat_req), .stat_hit(stat_hit),
        .stat_miss(stat_miss), .stat_err(stat_err)
`endif
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [275:0] act, input logic [275:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- abstract model ----------------
    int           cyc = 0;
    int           m_next_ok = 0;
    int           m_cnt = 0;
    bit           m_err = 1'b0;
    bit           m_rv = 1'b0, m_rerr = 1'b0, m_rhit = 1'b0;
    logic [7:0]   m_rtag = '0;
    logic [14:0]  m_rvid = '0;
    logic [7:0]   m_q[$];
    bit           m_lv[16];
    logic [127:0] m_lk[16];
    int           s_req = 0, s_hit = 0, s_miss = 0, s_err = 0;

    always @(negedge clk) begin
        bit acc;
        logic [275:0] k;
        cyc++;
        if (!rst_n) begin
            chk("rst_lu_vld", lu_vld, 0);
            chk("rst_lu_key", lu_key, 0);
            chk("rst_rsp_vld", rsp_vld, 0);
            chk("rst_rsp_tag", rsp_tag, 0);
            chk("rst_outst", outst_cnt, 0);
            chk("rst_err", err_unexp_done, 0);
            chk("rst_req_rdy", req_rdy, 1);
            m_q.delete();
            m_cnt = 0; m_err = 1'b0; m_next_ok = 0;
            m_rv = 1'b0; m_rerr = 1'b0; m_rhit = 1'b0; m_rtag = '0; m_rvid = '0;
            for (int i = 0; i < 16; i++) begin m_lv[i] = 1'b0; m_lk[i] = '0; end
            s_req = 0; s_hit = 0; s_miss = 0; s_err = 0;
        end else begin
            acc = req_vld && (m_cnt < 16) && (cyc >= m_next_ok);
            chk("req_rdy", req_rdy, (m_cnt < 16) && (cyc >= m_next_ok));
            chk("lu_vld", lu_vld, m_lv[cyc % 16]);
            chk("lu_key", lu_key, m_lk[cyc % 16]);
            chk("rsp_vld", rsp_vld, m_rv);
            chk("rsp_tag", rsp_tag, m_rtag);
            chk("rsp_err", rsp_err, m_rerr);
            chk("rsp_hit", rsp_hit, m_rhit);
            chk("rsp_vid", rsp_vid, m_rvid);
            chk("outst_cnt", outst_cnt, m_cnt);
            chk("err_unexp", err_unexp_done, m_err);
`ifdef CLASS_LU_REQ_STATS_EN
            chk("stat_req", stat_req, s_req);
            chk("stat_hit", stat_hit, s_hit);
            chk("stat_miss", stat_miss, s_miss);
            chk("stat_err", stat_err, s_err);
`endif
            m_lv[cyc % 16] = 1'b0;
            m_lk[cyc % 16] = '0;
            m_rv = 1'b0;
            if (lu_done) begin
                if (m_q.size() > 0) begin
                    m_rtag = m_q.pop_front();
                    m_rerr = lu_err;
                    m_rhit = lu_hit_miss && !lu_err;
                    m_rvid = lu_vid;
                    m_rv = 1'b1;
                    m_cnt--;
                    if (lu_err) s_err++;
                    else if (lu_hit_miss) s_hit++;
                    else s_miss++;
                end else begin
                    m_err = 1'b1;
                    s_err++;
                end
            end
            if (acc) begin
                k = req_key;
                m_lv[(cyc + 1) % 16] = 1'b1;
                m_lk[(cyc + 1) % 16] = 128'(k >> 148);
                m_lk[(cyc + 2) % 16] = 128'(k >> 20);
                m_lk[(cyc + 3) % 16] = 128'(k & ((276'd1 << 20) - 276'd1)) << 108;
                m_next_ok = cyc + 4;
                m_q.push_back(req_tag);
                m_cnt++;
                s_req++;
            end
`ifdef CLASS_LU_REQ_STATS_EN
            if (stat_clr) begin s_req = 0; s_hit = 0; s_miss = 0; s_err = 0; end
`endif
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [275:0] key, input logic [7:0] tag);
        int n = 0;
        req_key = key;
        req_tag = tag;
        req_vld = 1'b1;
        while (!req_rdy && n < 200) begin step(); n++; end
        if (!req_rdy) begin
            n_chk++; n_fail++;
            $display("FAIL send_timeout: req_rdy got 0 expected 1 tag %0h", tag);
        end
        step();
    endtask

    task automatic done(input logic err, input logic hit, input logic [14:0] vid);
        lu_done = 1'b1; lu_err = err; lu_hit_miss = hit; lu_vid = vid;
        step();
        lu_done = 1'b0; lu_err = 1'b0; lu_hit_miss = 1'b0;
    endtask

    localparam logic [275:0] K1 =
        276'h1_23456789ABCDEF0_23456789ABCDEF0_23456789ABCDEF0_23456789ABCDEF0_123ABCDE;

    initial begin
        longint t_prev;
        repeat (3) step();
        rst_n = 1'b1;
        step();
        chk("init_rdy", req_rdy, 1);
        chk("init_outst", outst_cnt, 0);

        // single key, beat layout pinned by hand
        send(K1, 8'h5A);
        req_vld = 1'b0;
        chk("t1_b0_vld", lu_vld, 1);
        chk("t1_b0", lu_key, 128'h123456789ABCDEF023456789ABCDEF02);
        step();
        chk("t1_b1_vld", lu_vld, 0);
        chk("t1_b1", lu_key, 128'h3456789ABCDEF023456789ABCDEF0123);
        step();
        chk("t1_b2", lu_key, 128'hABCDE000_00000000_00000000_00000000);
        chk("t1_rdy_busy", req_rdy, 0);
        step();
        chk("t1_gap_key", lu_key, 0);
        done(1'b0, 1'b1, 15'h1234);
        chk("t1_rsp_vld", rsp_vld, 1);
        chk("t1_rsp_tag", rsp_tag, 8'h5A);
        chk("t1_rsp_hit", rsp_hit, 1);
        chk("t1_rsp_vid", rsp_vid, 15'h1234);
        chk("t1_outst", outst_cnt, 0);
        step();
        chk("t1_rsp_pulse", rsp_vld, 0);
        chk("t1_rsp_hold", rsp_tag, 8'h5A);

        // back-to-back keys with req_vld held high: 4-cycle start spacing
        for (int i = 0; i < 5; i++) begin
            send(K1 ^ (276'(i + 1) << 100) ^ 276'(i * 7), 8'(8'h10 + i));
            if (i > 0) chk("t2_spacing", $time - t_prev, 40);
            t_prev = $time;
        end
        req_vld = 1'b0;
        for (int i = 0; i < 5; i++) done(1'b0, 1'(i % 2), 15'(i + 100));

        // fill to the credit limit, then drain in order
        req_vld = 1'b1;
        for (int i = 0; i < 16; i++) send(K1 >> i, 8'(i));
        req_vld = 1'b0;
        repeat (3) step();
        chk("t3_full_rdy", req_rdy, 0);
        chk("t3_full_cnt", outst_cnt, 16);
        done(1'b0, 1'b0, 15'd0);
        chk("t3_first_tag", rsp_tag, 0);
        chk("t3_rdy_back", req_rdy, 1);
        for (int i = 1; i < 16; i++) done(1'b0, 1'(i % 3 == 0), 15'(i));
        chk("t3_last_tag", rsp_tag, 15);
        chk("t3_empty", outst_cnt, 0);

        // accept and done in the same cycle; error masks hit
        for (int i = 0; i < 3; i++) begin send(~K1 >> (i * 3), 8'(8'hA0 + i)); req_vld = 1'b0; end
        repeat (3) step();
        req_key = K1; req_tag = 8'hC3; req_vld = 1'b1;
        done(1'b1, 1'b1, 15'h7FFF);
        req_vld = 1'b0;
        chk("t4_cnt_same", outst_cnt, 3);
        chk("t4_rsp_err", rsp_err, 1);
        chk("t4_rsp_hit", rsp_hit, 0);
        chk("t4_rsp_tag", rsp_tag, 8'hA0);
        repeat (3) step();
        for (int i = 0; i < 3; i++) done(1'b0, 1'b1, 15'(i + 9));
        chk("t4_drain_tag", rsp_tag, 8'hC3);

        // unexpected done, then reset during BEAT1
        done(1'b0, 1'b1, 15'h55);
        chk("t5_err", err_unexp_done, 1);
        chk("t5_no_rsp", rsp_vld, 0);
        repeat (3) step();
        chk("t5_sticky", err_unexp_done, 1);
        send(K1, 8'h77);
        req_vld = 1'b0;
        chk("t5_beat1_vld", lu_vld, 1);
        rst_n = 1'b0;
        #1;
        chk("t5_async_vld", lu_vld, 0);
        chk("t5_async_key", lu_key, 0);
        chk("t5_async_cnt", outst_cnt, 0);
        chk("t5_async_err", err_unexp_done, 0);
        step();
        step();
        rst_n = 1'b1;
        step();
        chk("t5_post_rdy", req_rdy, 1);

`ifdef CLASS_LU_REQ_STATS_EN
        // statistics: 3 hits, 2 misses, 1 error
        for (int i = 0; i < 6; i++) begin
            send(K1 + 276'(i), 8'(i));
            req_vld = 1'b0;
            done(1'(i == 5), 1'(i < 3), 15'(i));
        end
        chk("st_req", stat_req, 6);
        chk("st_hit", stat_hit, 3);
        chk("st_miss", stat_miss, 2);
        chk("st_err", stat_err, 1);
        stat_clr = 1'b1;
        step();
        stat_clr = 1'b0;
        chk("st_clr_req", stat_req, 0);
        chk("st_clr_err", stat_err, 0);
`endif

        repeat (4) step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
